// File: rtl/countdown_timer.sv
// MM:SS.cc BCD countdown timer: debounced start/pause and load keys, 10 ms tick prescaler, alarm at zero.
// Digits, running and expired are registered and update on the edge that sees the key event or tick.
module countdown_timer #(
  parameter int delay        = 500000,
  parameter int two_ms_delay = 100000
) (
  input  logic       clock,
  input  logic       key_reset,
  input  logic       key_start_pause,
  input  logic       key_load,
  input  logic [3:0] min_higher_preset,
  input  logic [3:0] min_lower_preset,
  input  logic [3:0] s_higher_preset,
  input  logic [3:0] s_lower_preset,
  output logic [3:0] min_higher_display,
  output logic [3:0] min_lower_display,
  output logic [3:0] s_higher_display,
  output logic [3:0] s_lower_display,
  output logic [3:0] ms_higher_display,
  output logic [3:0] ms_lower_display,
  output logic       running,
  output logic       expired
);

  localparam int PW = $clog2(delay);
  localparam int DW = $clog2(two_ms_delay + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(delay - 1);
  localparam logic [DW-1:0] DB_MAX     = DW'(two_ms_delay);
  localparam logic [DW-1:0] DB_ARM     = DW'(two_ms_delay - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [DW-1:0] db_start_q, db_load_q;
  logic [23:0]   time_q;
  logic [23:0]   dec_time_d;
  logic [23:0]   preset_time;
  logic          running_q, expired_q;
  logic          start_evt, load_evt, tick, time_zero, last_hundredth;

  always_ff @(posedge clock or negedge key_reset) begin
    if (!key_reset) begin
      db_start_q <= '0;
      db_load_q  <= '0;
    end else begin
      if (key_start_pause)           db_start_q <= '0;
      else if (db_start_q != DB_MAX) db_start_q <= db_start_q + 1'b1;
      if (key_load)                  db_load_q  <= '0;
      else if (db_load_q != DB_MAX)  db_load_q  <= db_load_q + 1'b1;
    end
  end

  // The event fires on the edge where the counter steps onto its saturation value.
  assign start_evt = !key_start_pause && (db_start_q == DB_ARM);
  assign load_evt  = !key_load && (db_load_q == DB_ARM);

  assign preset_time = {(min_higher_preset > 4'd5) ? 4'd5 : min_higher_preset,
                        (min_lower_preset  > 4'd9) ? 4'd9 : min_lower_preset,
                        (s_higher_preset   > 4'd5) ? 4'd5 : s_higher_preset,
                        (s_lower_preset    > 4'd9) ? 4'd9 : s_lower_preset,
                        8'h00};

  assign tick           = (presc_q == PRESC_LAST);
  assign time_zero      = (time_q == 24'h000000);
  assign last_hundredth = (time_q == 24'h000001);

  // Borrow chain; minute tens is only reached when nonzero because RUNNING never holds zero.
  always_comb begin
    dec_time_d = time_q;
    if (time_q[3:0] != 4'd0) dec_time_d[3:0] = time_q[3:0] - 4'd1;
    else begin
      dec_time_d[3:0] = 4'd9;
      if (time_q[7:4] != 4'd0) dec_time_d[7:4] = time_q[7:4] - 4'd1;
      else begin
        dec_time_d[7:4] = 4'd9;
        if (time_q[11:8] != 4'd0) dec_time_d[11:8] = time_q[11:8] - 4'd1;
        else begin
          dec_time_d[11:8] = 4'd9;
          if (time_q[15:12] != 4'd0) dec_time_d[15:12] = time_q[15:12] - 4'd1;
          else begin
            dec_time_d[15:12] = 4'd5;
            if (time_q[19:16] != 4'd0) dec_time_d[19:16] = time_q[19:16] - 4'd1;
            else begin
              dec_time_d[19:16] = 4'd9;
              dec_time_d[23:20] = time_q[23:20] - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge key_reset) begin
    if (!key_reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      time_q    <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_evt) time_q <= preset_time;
          else if (start_evt && !time_zero) begin
            state_q   <= RUNNING;
            running_q <= 1'b1;
          end
        end
        RUNNING: begin
          if (tick) begin
            presc_q <= '0;
            time_q  <= dec_time_d;
          end else begin
            presc_q <= presc_q + 1'b1;
          end
          // Expiry outranks a pause landing on the same edge.
          if (tick && last_hundredth) begin
            state_q   <= EXPIRED;
            running_q <= 1'b0;
            expired_q <= 1'b1;
          end else if (start_evt) begin
            state_q   <= PAUSED;
            running_q <= 1'b0;
          end
        end
        PAUSED: begin
          if (load_evt) begin
            time_q  <= preset_time;
            presc_q <= '0;
            state_q <= IDLE;
          end else if (start_evt) begin
            state_q   <= RUNNING;
            running_q <= 1'b1;
          end
        end
        EXPIRED: begin
          if (load_evt || start_evt) begin
            if (load_evt) time_q <= preset_time;
            state_q   <= IDLE;
            expired_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
          expired_q <= 1'b0;
        end
      endcase
    end
  end

  assign min_higher_display = time_q[23:20];
  assign min_lower_display  = time_q[19:16];
  assign s_higher_display   = time_q[15:12];
  assign s_lower_display    = time_q[11:8];
  assign ms_higher_display  = time_q[7:4];
  assign ms_lower_display   = time_q[3:0];
  assign running            = running_q;
  assign expired            = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomised bench for countdown_timer against a hundredths-count reference model.
module tb_countdown_timer;
  localparam int DLY = 4;
  localparam int DB  = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       key_reset, key_start_pause, key_load;
  logic [3:0] p_mh, p_ml, p_sh, p_sl;
  logic [3:0] d_mh, d_ml, d_sh, d_sl, d_hh, d_hl;
  logic       running, expired;

  countdown_timer #(.delay(DLY), .two_ms_delay(DB)) dut (
    .clock              (clock),
    .key_reset          (key_reset),
    .key_start_pause    (key_start_pause),
    .key_load           (key_load),
    .min_higher_preset  (p_mh),
    .min_lower_preset   (p_ml),
    .s_higher_preset    (p_sh),
    .s_lower_preset     (p_sl),
    .min_higher_display (d_mh),
    .min_lower_display  (d_ml),
    .s_higher_display   (d_sh),
    .s_lower_display    (d_sl),
    .ms_higher_display  (d_hh),
    .ms_lower_display   (d_hl),
    .running            (running),
    .expired            (expired)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: m_state 0 idle, 1 running, 2 paused, 3 expired; time kept as total hundredths.
  int m_state = 0, m_total = 0, m_frac = 0, m_cnt_s = 0, m_cnt_l = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampv(input logic [3:0] v, input int mx);
    return (int'(v) > mx) ? mx : int'(v);
  endfunction

  function automatic int preset_total();
    int mins, secs;
    mins = clampv(p_mh, 5) * 10 + clampv(p_ml, 9);
    secs = clampv(p_sh, 5) * 10 + clampv(p_sl, 9);
    return (mins * 60 + secs) * 100;
  endfunction

  function automatic logic [23:0] exp_digits();
    int mm, ss, cc;
    mm = m_total / 6000;
    ss = (m_total / 100) % 60;
    cc = m_total % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic logic [23:0] dut_digits();
    return {d_mh, d_ml, d_sh, d_sl, d_hh, d_hl};
  endfunction

  task automatic model_reset();
    m_state = 0; m_total = 0; m_frac = 0; m_cnt_s = 0; m_cnt_l = 0;
  endtask

  task automatic model_edge();
    bit ev_s, ev_l;
    ev_s = 1'b0;
    ev_l = 1'b0;
    if (key_start_pause) m_cnt_s = 0;
    else if (m_cnt_s < DB) begin m_cnt_s++; ev_s = (m_cnt_s == DB); end
    if (key_load) m_cnt_l = 0;
    else if (m_cnt_l < DB) begin m_cnt_l++; ev_l = (m_cnt_l == DB); end
    case (m_state)
      0: if (ev_l) m_total = preset_total();
         else if (ev_s && m_total != 0) m_state = 1;
      1: begin
        m_frac++;
        if (m_frac == DLY) begin
          m_frac = 0;
          m_total--;
        end
        if (m_total == 0) m_state = 3;
        else if (ev_s) m_state = 2;
      end
      2: if (ev_l) begin m_total = preset_total(); m_frac = 0; m_state = 0; end
         else if (ev_s) m_state = 1;
      default: if (ev_l) begin m_total = preset_total(); m_state = 0; end
               else if (ev_s) m_state = 0;
    endcase
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    #1;
    check("model", {6'd0, dut_digits(), running, expired},
          {6'd0, exp_digits(), 1'(m_state == 1), 1'(m_state == 3)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press(input bit s, input bit l, input int n);
    key_start_pause = !s;
    key_load        = !l;
    for (int i = 0; i < n; i++) cycle();
    key_start_pause = 1'b1;
    key_load        = 1'b1;
  endtask

  task automatic set_preset(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    p_mh = a; p_ml = b; p_sh = c; p_sl = d;
  endtask

  initial begin
    key_reset = 1'b0; key_start_pause = 1'b1; key_load = 1'b1;
    set_preset(4'd0, 4'd0, 4'd0, 4'd0);
    #12;
    check("rst_digits", {8'd0, dut_digits()}, 32'h0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_expired", {31'd0, expired}, 32'd0);
    model_reset();
    #5 key_reset = 1'b1;

    // Short load press must not register.
    set_preset(4'd0, 4'd0, 4'd0, 4'd2);
    press(1'b0, 1'b1, 2);
    idle(2);
    check("short_load", {8'd0, dut_digits()}, 32'h0);

    // Held load fires once; a changed preset during the hold is not reloaded.
    key_load = 1'b0;
    idle(3);
    check("load_once", {8'd0, dut_digits()}, 32'h000200);
    set_preset(4'd0, 4'd0, 4'd0, 4'd3);
    idle(4);
    check("load_held", {8'd0, dut_digits()}, 32'h000200);
    key_load = 1'b1;
    idle(2);

    press(1'b1, 1'b0, 3);
    check("start_running", {31'd0, running}, 32'd1);
    for (int n = 1; n <= 800; n++) begin
      cycle();
      if (n == 4)   check("first_tick", {8'd0, dut_digits()}, 32'h000199);
      if (n == 799) check("pre_expire", {30'd0, running, expired}, 32'b10);
    end
    check("expire_flags", {30'd0, running, expired}, 32'b01);
    check("expire_digits", {8'd0, dut_digits()}, 32'h0);

    press(1'b1, 1'b0, 3);
    check("ack_idle", {30'd0, running, expired}, 32'b00);

    // Minute borrow chain, then pause two cycles into a tick.
    set_preset(4'd1, 4'd0, 4'd0, 4'd0);
    press(1'b0, 1'b1, 3);
    idle(1);
    press(1'b1, 1'b0, 3);
    idle(3);
    key_start_pause = 1'b0;
    cycle();
    check("borrow_all", {8'd0, dut_digits()}, 32'h095999);
    idle(2);
    key_start_pause = 1'b1;
    check("paused", {31'd0, running}, 32'd0);
    idle(10);
    check("pause_hold", {8'd0, dut_digits()}, 32'h095999);
    press(1'b1, 1'b0, 3);
    check("resumed", {31'd0, running}, 32'd1);
    cycle();
    check("resume_frac1", {8'd0, dut_digits()}, 32'h095999);
    cycle();
    check("resume_frac2", {8'd0, dut_digits()}, 32'h095998);

    // Asynchronous reset mid-run.
    idle(5);
    #2 key_reset = 1'b0;
    #1;
    check("async_rst", {6'd0, dut_digits(), running, expired}, 32'h0);
    model_reset();
    idle(1);
    #2 key_reset = 1'b1;
    idle(1);

    // Simultaneous load and start in IDLE: load wins, stays idle.
    set_preset(4'd0, 4'd1, 4'd3, 4'd0);
    press(1'b1, 1'b1, 3);
    check("both_keys", {7'd0, dut_digits(), running}, {7'd0, 24'h013000, 1'b0});
    idle(2);

    set_preset(4'd7, 4'd12, 4'd9, 4'd15);
    press(1'b0, 1'b1, 3);
    check("clamp", {8'd0, dut_digits()}, 32'h595900);
    idle(2);

    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) != 0) set_preset(4'd0, 4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      else set_preset(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      case ($urandom_range(0, 2))
        0: press(1'b1, 1'b0, $urandom_range(1, 5));
        1: press(1'b0, 1'b1, $urandom_range(1, 5));
        default: press(1'b1, 1'b1, $urandom_range(1, 5));
      endcase
      idle($urandom_range(1, 120));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
